// File: rtl/schoolbook_pkg.sv
// Shared widths, FSM encoding and constants for the restoring divider.
package schoolbook_pkg;
    localparam int SB_N     = 409;
    localparam int SB_W2    = 2 * SB_N;
    localparam int SB_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Quotient reported for a zero divisor.
    localparam logic [SB_W2-1:0] SB_DBZ_Q = {SB_W2{1'b1}};
endpackage

// File: rtl/schoolbook_div_step.sv
// One restoring-division step: compare the shifted partial remainder against the divisor.
module schoolbook_div_step
    import schoolbook_pkg::*;
#(
    parameter int N = SB_N
) (
    input  logic [N:0]   t,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_nxt,
    output logic         qbit
);
    logic [N:0] dext;

    // t < 2*divisor always holds, so the result is below divisor and fits N bits.
    always_comb begin
        dext    = {1'b0, divisor};
        qbit    = (t >= dext);
        rem_nxt = qbit ? N'(t - dext) : t[N-1:0];
    end
endmodule

// File: rtl/schoolbook_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module schoolbook_div
    import schoolbook_pkg::*;
#(
    parameter int N     = SB_N,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r
);
    localparam int              W2   = 2 * N;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W2 - 1);

    state_t           state, state_nxt;
    logic [W2-1:0]    dq;       // dividend bits leave at the top, quotient bits enter at the bottom
    logic [N-1:0]     dvsr;
    logic [N-1:0]     rem;
    logic [N:0]       t;        // N+1-bit partial remainder presented to the compare
    logic [N-1:0]     rem_nxt;
    logic             qbit;
    logic             accept;
    logic             last;
    logic [CNT_W-1:0] cnt;

    assign t = {rem, dq[W2-1]};

    schoolbook_div_step #(.N(N)) u_step (
        .t       (t),
        .divisor (dvsr),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (b == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers load only on the edge entering FIN, so they hold across later starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq          <= '0;
            dvsr        <= '0;
            rem         <= '0;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dq          <= a;
            dvsr        <= b;
            rem         <= '0;
            cnt         <= '0;
            div_by_zero <= (b == '0);
            if (b == '0) begin
                q <= SB_DBZ_Q;
                r <= '0;
            end
        end else if (state == CALC) begin
            dq  <= {dq[W2-2:0], qbit};
            rem <= rem_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                q <= {dq[W2-2:0], qbit};
                r <= rem_nxt;
            end
        end
    end
endmodule
